// File: rtl/cbus_mem_responder_if.sv
// Cache-bus channel bundle: request struct (master -> responder) and response struct (responder -> master).
// Latency: none; this is wiring only.
// Backpressure: the responder paces beats with cresp.ready; the master holds creq stable while creq.valid=1.
//   creq : valid, is_write, size, addr, strobe, data, len, burst
//   cresp: ready, last, data
interface cbus_mem_responder_if;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;     // bytes per beat = 1 << size
    logic [63:0] addr;
    logic [7:0]  strobe;   // byte-lane enables, lane-aligned to the 64-bit word
    logic [63:0] data;
    logic [7:0]  len;      // beats - 1
    logic [1:0]  burst;    // 0 FIXED, 1 INCR, 2 WRAP, 3 reserved (acts as INCR)
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

  cbus_req_t  creq;
  cbus_resp_t cresp;

  modport master (output creq, input cresp);
  modport slave  (input creq, output cresp);

endinterface

// File: rtl/cbus_mem_responder.sv
// Burst memory responder behind the cache bus, backed by a 64-bit word array.
// Latency: READ_LATENCY idle cycles after acceptance, then one beat per cycle; all cresp fields registered.
// Backpressure: none toward the master; dropping creq.valid mid-transaction aborts it.
//   clk, resetn : clock, asynchronous active-low reset
//   bus         : slave side of the cbus channel (creq in, cresp out)
module cbus_mem_responder #(
  parameter int          MEM_WORDS    = 4096,
  parameter logic [63:0] BASE_ADDR    = 64'h0000_0000_8000_0000,
  parameter int          READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  cbus_mem_responder_if.slave   bus
);

  localparam int          IDX_W    = $clog2(MEM_WORDS);
  localparam logic [1:0]  BT_FIXED = 2'd0;
  localparam logic [1:0]  BT_WRAP  = 2'd2;
  localparam logic [3:0]  LAT_LAST = 4'((READ_LATENCY > 0) ? (READ_LATENCY - 1) : 0);

  typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_e;

  state_e      state_q, state_d;
  logic        is_write_q, is_write_d;
  logic [2:0]  size_q, size_d;
  logic [7:0]  len_q, len_d;
  logic [1:0]  burst_q, burst_d;
  logic [63:0] cur_addr_q, cur_addr_d;
  logic [7:0]  beat_q, beat_d;
  logic [3:0]  lat_q, lat_d;
  logic        ready_q, ready_d;
  logic        last_q, last_d;
  logic [63:0] rdata_q, rdata_d;

  logic [63:0] mem [MEM_WORDS];

  logic             mem_we;
  logic [63:0]      wr_off, rd_off;
  logic             wr_hit, rd_hit;
  logic [IDX_W-1:0] wr_idx, rd_idx;

  // Next beat address. WRAP keeps the upper bits of the (len+1)*step block and
  // lets only the in-block offset advance and roll over.
  function automatic logic [63:0] next_addr(input logic [63:0] a, input logic [2:0] sz,
                                            input logic [7:0] ln, input logic [1:0] bt);
    logic [63:0] step;
    logic [63:0] mask;
    step = 64'd1 << sz;
    mask = (({56'd0, ln} + 64'd1) << sz) - 64'd1;
    if (bt == BT_FIXED)
      next_addr = a;
    else if (bt == BT_WRAP)
      next_addr = (a & ~mask) | ((a + step) & mask);
    else
      next_addr = a + step;
  endfunction

  // Write decode uses the beat currently on the bus.
  always_comb begin
    wr_off = cur_addr_q - BASE_ADDR;
    wr_hit = (cur_addr_q >= BASE_ADDR) && ((wr_off >> 3) < 64'(MEM_WORDS));
    wr_idx = wr_off[IDX_W+2:3];
  end

  // Read decode looks one beat ahead so read data lands in the same cycle as ready.
  always_comb begin
    rd_off = cur_addr_d - BASE_ADDR;
    rd_hit = (cur_addr_d >= BASE_ADDR) && ((rd_off >> 3) < 64'(MEM_WORDS));
    rd_idx = rd_off[IDX_W+2:3];
  end

  always_comb begin
    state_d    = state_q;
    is_write_d = is_write_q;
    size_d     = size_q;
    len_d      = len_q;
    burst_d    = burst_q;
    cur_addr_d = cur_addr_q;
    beat_d     = beat_q;
    lat_d      = lat_q;
    mem_we     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.creq.valid) begin
          is_write_d = bus.creq.is_write;
          size_d     = bus.creq.size;
          len_d      = bus.creq.len;
          burst_d    = bus.creq.burst;
          cur_addr_d = bus.creq.addr;
          beat_d     = 8'd0;
          lat_d      = 4'd0;
          if (READ_LATENCY > 0)
            state_d = WAIT;
          else
            state_d = BURST;
        end
      end
      WAIT: begin
        if (!bus.creq.valid)
          state_d = IDLE;
        else if (lat_q == LAT_LAST)
          state_d = BURST;
        else
          lat_d = lat_q + 4'd1;
      end
      BURST: begin
        if (!bus.creq.valid) begin
          state_d = IDLE;
        end else begin
          // Out-of-range write beats still complete, they just touch nothing.
          mem_we = is_write_q && wr_hit;
          if (beat_q == len_q) begin
            state_d = DONE;
          end else begin
            beat_d     = beat_q + 8'd1;
            cur_addr_d = next_addr(cur_addr_q, size_q, len_q, burst_q);
          end
        end
      end
      DONE: begin
        // Wait for valid to fall so a held request is not served twice.
        if (!bus.creq.valid)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == BURST);
    last_d  = ready_d && (beat_d == len_d);
    rdata_d = 64'd0;
    if (ready_d && !is_write_d && rd_hit)
      rdata_d = mem[rd_idx];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      is_write_q <= 1'b0;
      size_q     <= 3'd0;
      len_q      <= 8'd0;
      burst_q    <= 2'd0;
      cur_addr_q <= 64'd0;
      beat_q     <= 8'd0;
      lat_q      <= 4'd0;
      ready_q    <= 1'b0;
      last_q     <= 1'b0;
      rdata_q    <= 64'd0;
    end else begin
      state_q    <= state_d;
      is_write_q <= is_write_d;
      size_q     <= size_d;
      len_q      <= len_d;
      burst_q    <= burst_d;
      cur_addr_q <= cur_addr_d;
      beat_q     <= beat_d;
      lat_q      <= lat_d;
      ready_q    <= ready_d;
      last_q     <= last_d;
      rdata_q    <= rdata_d;
    end
  end

  // Array is deliberately not reset; strobed byte lanes only.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 8; i++) begin
        if (bus.creq.strobe[i])
          mem[wr_idx][8*i +: 8] <= bus.creq.data[8*i +: 8];
      end
    end
  end

  assign bus.cresp.ready = ready_q;
  assign bus.cresp.last  = last_q;
  assign bus.cresp.data  = rdata_q;

endmodule

// File: tb/tb_cbus_mem_responder.sv
module tb_cbus_mem_responder;

  localparam int          MW   = 64;
  localparam int          RL   = 2;
  localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  cbus_mem_responder_if bus();

  cbus_mem_responder #(.MEM_WORDS(MW), .BASE_ADDR(BASE), .READ_LATENCY(RL)) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  logic [63:0] mdl   [MW];
  logic [63:0] wdata [256];
  logic [7:0]  wstrb [256];
  logic [63:0] rdat  [256];
  int          got_beats;

  typedef struct {
    logic        wr;
    logic [2:0]  sz;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [1:0]  bst;
    logic [7:0]  strb;
    logic [63:0] d0;
    int          exp_beats;
    logic [63:0] exp_first;
    logic [63:0] exp_last;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: plain byte/word arithmetic over a flat array.
  function automatic logic [63:0] m_next(input logic [63:0] a, input logic [2:0] sz,
                                         input logic [7:0] ln, input logic [1:0] bt);
    logic [63:0] step, blk, base;
    step = 64'd1 << sz;
    if (bt == 2'd0) begin
      m_next = a;
    end else if (bt == 2'd2) begin
      blk    = (64'(ln) + 64'd1) * step;
      base   = (a / blk) * blk;
      m_next = base + ((a - base + step) % blk);
    end else begin
      m_next = a + step;
    end
  endfunction

  function automatic logic [63:0] m_rd(input logic [63:0] a);
    if (a < BASE || ((a - BASE) / 8) >= 64'(MW))
      m_rd = 64'd0;
    else
      m_rd = mdl[int'((a - BASE) / 8)];
  endfunction

  task automatic m_wr(input logic [63:0] a, input logic [7:0] s, input logic [63:0] d);
    if (!(a < BASE || ((a - BASE) / 8) >= 64'(MW))) begin
      for (int i = 0; i < 8; i++)
        if (s[i]) mdl[int'((a - BASE) / 8)][8*i +: 8] = d[8*i +: 8];
    end
  endtask

  // One transaction as the master. abort_after>0 drops valid after that many beats;
  // hold = cycles valid stays high after last. Returns with valid low and the DUT idle.
  task automatic xfer(input logic wr, input logic [2:0] sz, input logic [63:0] addr,
                      input logic [7:0] len, input logic [1:0] bst,
                      input int abort_after, input int hold);
    logic [63:0] a;
    int nb, lat, cyc;
    bit done;
    a = addr; nb = 0; lat = -1; cyc = 0; done = 0;
    bus.creq.is_write = wr;
    bus.creq.size     = sz;
    bus.creq.addr     = addr;
    bus.creq.len      = len;
    bus.creq.burst    = bst;
    bus.creq.data     = wdata[0];
    bus.creq.strobe   = wstrb[0];
    bus.creq.valid    = 1'b1;
    while (!done && cyc < 600) begin
      @(posedge clk); #1;
      cyc++;
      bus.creq.data   = wdata[nb];
      bus.creq.strobe = wstrb[nb];
      @(negedge clk);
      if (bus.cresp.ready) begin
        if (nb == 0) lat = cyc;
        chk($sformatf("last_b%0d", nb), 64'(bus.cresp.last), 64'(nb == int'(len)));
        chk($sformatf("data_b%0d", nb), bus.cresp.data, wr ? 64'd0 : m_rd(a));
        rdat[nb] = bus.cresp.data;
        if (wr) m_wr(a, wstrb[nb], wdata[nb]);
        a = m_next(a, sz, len, bst);
        nb++;
        if (nb == int'(len) + 1 || nb == abort_after) done = 1;
      end else if (nb > 0) begin
        chk("ready_gap", 64'(bus.cresp.ready), 64'd1);
        done = 1;
      end
    end
    got_beats = nb;
    chk("first_latency", 64'(lat), 64'(RL + 1));
    if (abort_after > 0) begin
      chk("abort_beats", 64'(nb), 64'(abort_after));
      @(posedge clk); #1;
      bus.creq.valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("abort_ready_low", 64'(bus.cresp.ready), 64'd0);
    end else begin
      chk("beats", 64'(nb), 64'(int'(len) + 1));
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        chk("done_ready_low", 64'(bus.cresp.ready), 64'd0);
      end
      @(posedge clk); #1;
      bus.creq.valid = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  // Raise a request and return at the first negedge showing ready (bounded).
  task automatic start_until_ready(input logic wr, input logic [63:0] addr, input logic [7:0] len);
    int cnt;
    bus.creq.is_write = wr;
    bus.creq.size     = 3'd3;
    bus.creq.addr     = addr;
    bus.creq.len      = len;
    bus.creq.burst    = 2'd1;
    bus.creq.data     = wdata[0];
    bus.creq.strobe   = wstrb[0];
    bus.creq.valid    = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!bus.cresp.ready && cnt < 20);
    chk("start_ready_seen", 64'(bus.cresp.ready), 64'd1);
  endtask

  initial begin
    int nready;
    logic        rwr;
    logic [2:0]  rsz;
    logic [1:0]  rbt;
    logic [7:0]  rlen;
    logic [63:0] raddr;

    bus.creq = '0;

    //        wr   sz    addr                     len     bst  strb   d0                      beats first                 last
    tbl[0]  = '{1'b1, 3'd3, BASE,                  8'd0,   2'd1, 8'hFF, 64'hDEAD_BEEF_0123_4567, 1,   64'd0,                 64'd0};
    tbl[1]  = '{1'b0, 3'd3, BASE,                  8'd0,   2'd1, 8'hFF, 64'd0,                   1,   64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567};
    tbl[2]  = '{1'b1, 3'd3, BASE + 64'h100,        8'd15,  2'd1, 8'hFF, 64'd0,                   16,  64'd0,                 64'd0};
    tbl[3]  = '{1'b0, 3'd3, BASE + 64'h100,        8'd15,  2'd1, 8'hFF, 64'd0,                   16,  64'd0,                 64'd15};
    tbl[4]  = '{1'b0, 3'd3, BASE + 64'h128,        8'd7,   2'd2, 8'hFF, 64'd0,                   8,   64'd5,                 64'd4};
    tbl[5]  = '{1'b1, 3'd3, BASE,                  8'd0,   2'd1, 8'hFF, 64'd0,                   1,   64'd0,                 64'd0};
    tbl[6]  = '{1'b1, 3'd0, BASE + 64'h2,          8'd0,   2'd1, 8'h04, 64'h0000_0000_00CD_0000, 1,   64'd0,                 64'd0};
    tbl[7]  = '{1'b0, 3'd3, BASE,                  8'd0,   2'd1, 8'hFF, 64'd0,                   1,   64'h0000_0000_00CD_0000, 64'h0000_0000_00CD_0000};
    tbl[8]  = '{1'b1, 3'd3, 64'h0000_0000_7FFF_FFF8, 8'd0, 2'd1, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 1,   64'd0,                 64'd0};
    tbl[9]  = '{1'b0, 3'd3, 64'h0000_0000_7FFF_FFF8, 8'd0, 2'd1, 8'hFF, 64'd0,                   1,   64'd0,                 64'd0};
    tbl[10] = '{1'b0, 3'd3, BASE,                  8'd0,   2'd1, 8'hFF, 64'd0,                   1,   64'h0000_0000_00CD_0000, 64'h0000_0000_00CD_0000};
    tbl[11] = '{1'b1, 3'd3, BASE + 64'h1F8,        8'd1,   2'd1, 8'hFF, 64'h0000_0000_0000_00A5, 2,   64'd0,                 64'd0};
    tbl[12] = '{1'b0, 3'd3, BASE + 64'h1F8,        8'd1,   2'd1, 8'hFF, 64'd0,                   2,   64'h0000_0000_0000_00A5, 64'd0};
    tbl[13] = '{1'b0, 3'd3, BASE,                  8'd255, 2'd0, 8'hFF, 64'd0,                   256, 64'h0000_0000_00CD_0000, 64'h0000_0000_00CD_0000};

    // Reset state
    #12;
    chk("reset_ready", 64'(bus.cresp.ready), 64'd0);
    chk("reset_last",  64'(bus.cresp.last),  64'd0);
    chk("reset_data",  bus.cresp.data,       64'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 14; i++) begin
      for (int k = 0; k < 256; k++) begin
        wdata[k] = tbl[i].d0 + 64'(k);
        wstrb[k] = tbl[i].strb;
      end
      xfer(tbl[i].wr, tbl[i].sz, tbl[i].addr, tbl[i].len, tbl[i].bst, 0, 1);
      chk($sformatf("vec%0d_beats", i), 64'(got_beats), 64'(tbl[i].exp_beats));
      chk($sformatf("vec%0d_first", i), rdat[0], tbl[i].exp_first);
      chk($sformatf("vec%0d_last", i), rdat[(got_beats > 0) ? got_beats - 1 : 0], tbl[i].exp_last);
    end

    // Held valid after last: no re-trigger; then one low cycle restarts
    xfer(1'b0, 3'd3, BASE, 8'd0, 2'd1, 0, 5);
    xfer(1'b0, 3'd3, BASE + 64'h100, 8'd3, 2'd1, 0, 1);

    // Fill the whole array with known data
    for (int k = 0; k < MW; k++) begin
      wdata[k] = {$urandom, $urandom};
      wstrb[k] = 8'hFF;
    end
    xfer(1'b1, 3'd3, BASE, 8'(MW - 1), 2'd1, 0, 1);

    // Randomized transactions against the model
    for (int t = 0; t < 40; t++) begin
      rwr = 1'($urandom);
      rsz = 3'($urandom_range(0, 3));
      rbt = 2'($urandom);
      if (rbt == 2'd2) rlen = 8'((1 << $urandom_range(0, 4)) - 1);
      else             rlen = 8'($urandom_range(0, 15));
      raddr = BASE + 64'($urandom_range(0, 69)) * 8 + 64'(($urandom_range(0, 7) >> rsz) << rsz);
      if ($urandom_range(0, 9) == 0) raddr = BASE - 64'h80 + 64'($urandom_range(0, 7) * 8);
      for (int k = 0; k < 16; k++) begin
        wdata[k] = {$urandom, $urandom};
        wstrb[k] = 8'($urandom);
      end
      xfer(rwr, rsz, raddr, rlen, rbt, 0, 1);
    end

    // Abort after 3 beats of an 8-beat write: only beats 0..2 land
    for (int k = 0; k < 8; k++) begin
      wdata[k] = 64'h1000 + 64'(k);
      wstrb[k] = 8'hFF;
    end
    xfer(1'b1, 3'd3, BASE + 64'h40, 8'd7, 2'd1, 3, 0);
    xfer(1'b0, 3'd3, BASE + 64'h40, 8'd7, 2'd1, 0, 1);
    chk("abort_word2_written", rdat[2], 64'h1002);

    // Reset mid-WAIT: outputs cleared, the pending request is forgotten
    bus.creq.is_write = 1'b0;
    bus.creq.addr     = BASE;
    bus.creq.len      = 8'd0;
    bus.creq.valid    = 1'b1;
    @(posedge clk); #2;
    resetn = 1'b0;
    #1;
    chk("rst_wait_ready", 64'(bus.cresp.ready), 64'd0);
    chk("rst_wait_last",  64'(bus.cresp.last),  64'd0);
    chk("rst_wait_data",  bus.cresp.data,       64'd0);
    bus.creq.valid = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    nready = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.cresp.ready) nready++;
    end
    chk("rst_wait_no_beats", 64'(nready), 64'd0);

    // Reset mid-BURST of a read: asynchronous clear while data is on the bus
    start_until_ready(1'b0, BASE + 64'h100, 8'd7);
    #2;
    resetn = 1'b0;
    #1;
    chk("rst_burst_ready", 64'(bus.cresp.ready), 64'd0);
    chk("rst_burst_last",  64'(bus.cresp.last),  64'd0);
    chk("rst_burst_data",  bus.cresp.data,       64'd0);
    bus.creq.valid = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    // Reset mid-BURST of a write: the beat already written survives
    for (int k = 0; k < 8; k++) begin
      wdata[k] = 64'h2000 + 64'(k);
      wstrb[k] = 8'hFF;
    end
    start_until_ready(1'b1, BASE + 64'h80, 8'd7);
    @(posedge clk);
    m_wr(BASE + 64'h80, 8'hFF, wdata[0]);
    #2;
    resetn = 1'b0;
    #1;
    chk("rst_wr_ready", 64'(bus.cresp.ready), 64'd0);
    bus.creq.valid = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    xfer(1'b0, 3'd3, BASE + 64'h80, 8'd1, 2'd1, 0, 1);
    chk("rst_wr_kept", rdat[0], 64'h2000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
